// File: rtl/lim_dec_timer.sv
// lim_dec_timer: two-digit base-L countdown timer with load/start/stop control and expiry pulse
// Ports: clk, reset (async active-low); load with preset_hi/preset_lo (clamped to L-1);
// start/stop run control; tick count strobe; digit_hi/digit_lo, running, done all registered.
module lim_dec_timer #(
  parameter int L = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] preset_hi,
  input  logic [3:0] preset_lo,
  input  logic       start,
  input  logic       stop,
  input  logic       tick,
  output logic [3:0] digit_hi,
  output logic [3:0] digit_lo,
  output logic       running,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;
  localparam logic [3:0] MAX = 4'(L - 1);
  state_t state, state_nx;
  logic [3:0] hi_nx, lo_nx, clamp_hi, clamp_lo, dec_hi, dec_lo;
  logic done_nx, go;
  assign clamp_hi = {1'b0, preset_hi} >= 5'(L) ? MAX : preset_hi;
  assign clamp_lo = {1'b0, preset_lo} >= 5'(L) ? MAX : preset_lo;
  assign dec_lo   = digit_lo == 4'd0 ? MAX : digit_lo - 4'd1;
  assign dec_hi   = digit_lo == 4'd0 ? digit_hi - 4'd1 : digit_hi;
  // stop outranks start wherever both could act
  assign go       = start && !stop;
  always_comb begin
    state_nx = state;
    hi_nx    = digit_hi;
    lo_nx    = digit_lo;
    done_nx  = 1'b0;
    if (load) begin
      state_nx = IDLE;
      hi_nx    = clamp_hi;
      lo_nx    = clamp_lo;
    end else begin
      case (state)
        IDLE:    if (go && (digit_hi != 4'd0 || digit_lo != 4'd0)) state_nx = RUN;
        RUN:
          if (stop) state_nx = PAUSE;
          else if (tick) begin
            hi_nx = dec_hi;
            lo_nx = dec_lo;
            // 01 is the only count whose decrement lands on 00
            if (digit_hi == 4'd0 && digit_lo == 4'd1) begin
              state_nx = EXPIRED;
              done_nx  = 1'b1;
            end
          end
        PAUSE:   if (go) state_nx = RUN;
        EXPIRED: if (go) state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      digit_hi <= 4'd0;
      digit_lo <= 4'd0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      digit_hi <= hi_nx;
      digit_lo <= lo_nx;
      running  <= state_nx == RUN;
      done     <= done_nx;
    end
  end
endmodule

// File: tb/tb_lim_dec_timer.sv
// tb_lim_dec_timer: randomized and directed checks of lim_dec_timer (L=10 and L=11) against a count-value model
module tb_lim_dec_timer;
  logic clk = 1'b0, reset = 1'b0;
  logic load = 1'b0, start = 1'b0, stop = 1'b0, tick = 1'b0;
  logic [3:0] preset_hi = 4'd0, preset_lo = 4'd0;
  logic [3:0] dh [2];
  logic [3:0] dl [2];
  logic run [2];
  logic dn [2];
  int checks = 0, failures = 0;
  int lv [2] = '{10, 11};
  int m_total [2];
  int m_mode [2];
  int m_done [2];
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
  always #5 clk = ~clk;
  lim_dec_timer #(.L(10)) u10 (
    .clk(clk), .reset(reset), .load(load), .preset_hi(preset_hi), .preset_lo(preset_lo),
    .start(start), .stop(stop), .tick(tick), .digit_hi(dh[0]), .digit_lo(dl[0]),
    .running(run[0]), .done(dn[0])
  );
  lim_dec_timer #(.L(11)) u11 (
    .clk(clk), .reset(reset), .load(load), .preset_hi(preset_hi), .preset_lo(preset_lo),
    .start(start), .stop(stop), .tick(tick), .digit_hi(dh[1]), .digit_lo(dl[1]),
    .running(run[1]), .done(dn[1])
  );
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", n, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_total[i] = 0;
      m_mode[i]  = M_IDLE;
      m_done[i]  = 0;
    end
  endtask
  // the count is kept as one integer; the digits are its base-L representation
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int ph, pl;
      m_done[i] = 0;
      ph = int'(preset_hi) >= lv[i] ? lv[i] - 1 : int'(preset_hi);
      pl = int'(preset_lo) >= lv[i] ? lv[i] - 1 : int'(preset_lo);
      if (load) begin
        m_total[i] = ph * lv[i] + pl;
        m_mode[i]  = M_IDLE;
      end else if (m_mode[i] == M_RUN) begin
        if (stop) m_mode[i] = M_PAUSE;
        else if (tick) begin
          m_total[i]--;
          if (m_total[i] == 0) begin
            m_mode[i] = M_EXP;
            m_done[i] = 1;
          end
        end
      end else if (start && !stop) begin
        if (m_mode[i] == M_PAUSE) m_mode[i] = M_RUN;
        else if (m_mode[i] == M_EXP) m_mode[i] = M_IDLE;
        else if (m_total[i] != 0) m_mode[i] = M_RUN;
      end
    end
  endtask
  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("hi[L=%0d]", lv[i]), 32'(dh[i]), 32'(m_total[i] / lv[i]));
      chk($sformatf("lo[L=%0d]", lv[i]), 32'(dl[i]), 32'(m_total[i] % lv[i]));
      chk($sformatf("running[L=%0d]", lv[i]), 32'(run[i]), 32'(m_mode[i] == M_RUN));
      chk($sformatf("done[L=%0d]", lv[i]), 32'(dn[i]), 32'(m_done[i]));
    end
  endtask
  task automatic step(input logic ld, input int ph, input int pl, input logic st, input logic sp, input logic tk);
    load = ld;
    preset_hi = 4'(ph);
    preset_lo = 4'(pl);
    start = st;
    stop = sp;
    tick = tk;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask
  initial begin
    int dones;
    model_reset();
    #12;
    chk("reset_hi", 32'(dh[0]), 0);
    chk("reset_lo", 32'(dl[0]), 0);
    chk("reset_running", 32'(run[0]), 0);
    chk("reset_done", 32'(dn[0]), 0);
    reset = 1'b1;
    step(1, 2, 3, 0, 0, 0);
    chk("load23", 32'({dh[0], dl[0]}), 32'h23);
    step(0, 0, 0, 1, 0, 0);
    chk("run_after_start", 32'(run[0]), 1);
    dones = 0;
    for (int k = 1; k <= 23; k++) begin
      step(0, 0, 0, 0, 0, 1);
      dones += int'(dn[0]);
      if (k == 1) chk("tick1_22", 32'({dh[0], dl[0]}), 32'h22);
      if (k == 14) chk("tick14_09", 32'({dh[0], dl[0]}), 32'h09);
    end
    chk("expire_00", 32'({dh[0], dl[0]}), 32'h00);
    chk("expire_done", 32'(dn[0]), 1);
    chk("expire_running", 32'(run[0]), 0);
    step(0, 0, 0, 0, 0, 1);
    dones += int'(dn[0]);
    chk("done_one_pulse", 32'(dones), 1);
    chk("frozen_00", 32'({dh[0], dl[0]}), 32'h00);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("wrap_09", 32'({dh[0], dl[0]}), 32'h09);
    step(1, 15, 12, 0, 0, 0);
    chk("clamp_L10", 32'({dh[0], dl[0]}), 32'h99);
    chk("clamp_L11_hi", 32'(dh[1]), 10);
    chk("clamp_L11_lo", 32'(dl[1]), 10);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("L11_tick_hi", 32'(dh[1]), 10);
    chk("L11_tick_lo", 32'(dl[1]), 9);
    step(1, 0, 5, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("pause_pre_03", 32'({dh[0], dl[0]}), 32'h03);
    step(0, 0, 0, 0, 1, 1);
    chk("stop_tick_03", 32'({dh[0], dl[0]}), 32'h03);
    chk("stop_tick_running", 32'(run[0]), 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1);
    chk("pause_hold_03", 32'({dh[0], dl[0]}), 32'h03);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("resume_02", 32'({dh[0], dl[0]}), 32'h02);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("zero_start_running", 32'(run[0]), 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 1);
    chk("zero_start_done", 32'(dn[0]), 0);
    step(1, 0, 9, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("mid_07", 32'({dh[0], dl[0]}), 32'h07);
    reset = 1'b0;
    model_reset();
    #2;
    chk("async_hi", 32'(dh[0]), 0);
    chk("async_lo", 32'(dl[0]), 0);
    chk("async_running", 32'(run[0]), 0);
    #4 reset = 1'b1;
    step(0, 0, 0, 0, 0, 1);
    chk("post_reset_hi", 32'(dh[0]), 0);
    chk("post_reset_lo", 32'(dl[0]), 0);
    chk("post_reset_running", 32'(run[0]), 0);
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        model_reset();
        #2;
        compare();
        #2 reset = 1'b1;
      end
      step($urandom_range(0, 15) == 0, $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    end
    if (checks == 0) failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lim_dec_timer.md
LIM_DEC_TIMER -- requirements
Module: lim_dec_timer

Interface
REQ-001 Parameter L, default 10: digit modulus; each digit counts down L-1..0; legal range 2..16.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 load  input  1  synchronous load of preset into the count.
REQ-005 preset_hi  input  4  preset value for the high digit.
REQ-006 preset_lo  input  4  preset value for the low digit.
REQ-007 start  input  1  request to begin or resume the countdown.
REQ-008 stop  input  1  request to pause the countdown.
REQ-009 tick  input  1  one-cycle count-enable strobe, e.g. 1 Hz from an external prescaler.
REQ-010 digit_hi  output  4  current high digit, registered.
REQ-011 digit_lo  output  4  current low digit, registered.
REQ-012 running  output  1  high while the FSM is in RUN.
REQ-013 done  output  1  one-cycle pulse when the count reaches 00 from RUN.

Function
REQ-014 The FSM SHALL have four states: IDLE, RUN, PAUSE and EXPIRED.
REQ-015 Transitions from IDLE:
- start with count != 00 -> RUN.
- start with count == 00 -> stays in IDLE.
REQ-016 Transitions from RUN:
- stop -> PAUSE.
- tick that makes the count 00 -> EXPIRED.
REQ-017 Transitions from PAUSE:
- start -> RUN.
- stop -> stays in PAUSE.
REQ-018 Transitions from EXPIRED: start or load -> IDLE (load also loads the preset).
REQ-019 Load behaviour:
- load in any state SHALL load the preset and force IDLE.
- load has priority over stop, start and tick in the same cycle.
REQ-020 Preset clamp: a preset digit >= L SHALL load as L-1, applied per digit independently.
REQ-021 Stop/start priority: stop SHALL have priority over start when both are asserted in the same cycle.
REQ-022 Decrement rule: count SHALL decrement only on a cycle with tick=1 in RUN (and no load or stop that cycle); latency of one cycle from the tick edge to the updated digits.
REQ-023 Low-digit wrap: decrement of digit_lo = 0 SHALL produce L-1 and borrow 1 into digit_hi; otherwise digit_lo-1 with no borrow.
REQ-024 High-digit borrow: digit_hi SHALL decrement only on a borrow; digit_hi is never decremented from 0 because expiry occurs first.
REQ-025 Expiry: the tick taking the count from 01 to 00 SHALL:
- enter EXPIRED;
- assert done for exactly that one following cycle;
- freeze the count at 00.
REQ-026 Ignored inputs: tick SHALL be ignored in IDLE, PAUSE and EXPIRED, and a tick held high for multiple cycles decrements once per cycle.
REQ-027 Stop/tick collision: stop and tick in the same RUN cycle SHALL give PAUSE with no decrement.
REQ-028 running SHALL be 1 exactly when the state is RUN; done SHALL be 0 except for the single expiry cycle.
REQ-029 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-030 reset=0 SHALL immediately, without waiting for clk, force:
- state IDLE;
- digit_hi=0 and digit_lo=0;
- running=0 and done=0.
REQ-031 reset asserted mid-countdown SHALL discard the count, and after release the block SHALL stay in IDLE until load or start.
REQ-032 The first active edge after reset release SHALL be processed normally.

Verification
REQ-033 L=10, load 2/3, start, then 23 ticks:
- digits step 23,22,...,10,09,...,01,00;
- done pulses once, for 1 cycle, on reaching 00;
- running falls in that cycle.
REQ-034 L=10, load 1/0, start, 1 tick -> digits 0/9, with the wrap and borrow producing 09.
REQ-035 L=11, load preset_hi=15 and preset_lo=12 -> digits 10/10; start plus 1 tick -> 10/9.
REQ-036 Load 0/5, start, 2 ticks giving 03, then:
- stop together with a tick -> PAUSE, digits still 03;
- 3 ticks -> still 03;
- start, then 1 tick -> 02.
REQ-037 Load 0/0, start -> remains IDLE, running=0, done never asserted.
REQ-038 Mid-run at 0/7, assert reset between clock edges -> outputs go to 0 before the next edge; after release a tick causes no change.
REQ-039 The bench SHALL track a pass flag and print a single pass/fail line naming the unit, failing if no checks executed.
